// File: rtl/rx_tlp_sender_pkg.sv
// rx_tlp_sender_pkg: FSM states, request kinds, TLP constants and sizing shared by rx_tlp_sender.
package rx_tlp_sender_pkg;
`ifndef BF
`define BF 9
`endif
    localparam int BF = `BF;
    localparam int PAGE_QW_BITS_DEF = 18;
    localparam int HDR_QW_DEF = 16;
    localparam logic [6:0] MWR64 = 7'b11_00000;
    localparam logic [7:0] TKEEP_ALL = 8'hFF;
    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_PAGE, S_HDR0, S_HDR1, S_DATA,
        S_CLOSE_HDR0, S_CLOSE_HDR1, S_CLOSE_DATA, S_SWITCH, S_ACK
    } state_t;
    typedef enum logic [1:0] {REQ_DATA, REQ_LAST, REQ_CHANGE} req_t;
endpackage

// File: rtl/rx_tlp_hdr_build.sv
// rx_tlp_hdr_build: formats the two 64-bit header beats of a 4DW MWr64 TLP.
module rx_tlp_hdr_build
    import rx_tlp_sender_pkg::*;
(
    input  logic [9:0]  length,
    input  logic [15:0] req_id,
    input  logic [63:0] addr,
    output logic [63:0] hdr0,
    output logic [63:0] hdr1
);
    assign hdr0 = {req_id, 8'h00, 4'hF, 4'hF, 1'b0, MWR64, 8'h00, 6'b0, length};
    assign hdr1 = {addr[31:2], 2'b00, addr[63:32]};
endmodule

// File: rtl/rx_tlp_sender.sv
// rx_tlp_sender: emits MWr64 data TLPs from the rx buffer into alternating host huge pages.
// Optional RX_TLP_SENDER_STATS_EN adds tlp_count / qword_count outputs.
module rx_tlp_sender
    import rx_tlp_sender_pkg::*;
#(
    parameter int PAGE_QW_BITS = PAGE_QW_BITS_DEF,
    parameter int HDR_QW = HDR_QW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          trigger_tlp,
    output logic          trigger_tlp_ack,
    input  logic          change_huge_page,
    input  logic          send_last_tlp,
    output logic          change_huge_page_ack,
    input  logic [4:0]    qwords_to_send,
    output logic [BF:0]   rd_addr,
    input  logic [63:0]   rd_data,
    input  logic [63:0]   huge_page_addr_1,
    input  logic [63:0]   huge_page_addr_2,
    input  logic          huge_page_status_1,
    input  logic          huge_page_status_2,
    output logic          huge_page_free_1,
    output logic          huge_page_free_2,
    input  logic [15:0]   cfg_completer_id,
    input  logic          s_axis_tx_tready,
    output logic [63:0]   s_axis_tx_tdata,
    output logic [7:0]    s_axis_tx_tkeep,
    output logic          s_axis_tx_tlast,
    output logic          s_axis_tx_tvalid
`ifdef RX_TLP_SENDER_STATS_EN
    ,
    output logic [31:0]   tlp_count,
    output logic [31:0]   qword_count
`endif
);
    state_t                state, state_nxt;
    req_t                  req;
    logic [4:0]            qw;
    logic [4:0]            idx;
    logic [BF:0]           rd_ptr;
    logic [PAGE_QW_BITS:0] offset;
    logic                  cur_page2;
    logic [63:0]           hold;
    logic                  hold_v;
    logic                  hs, last_beat, page_ready, closing, data_done;
    logic [63:0]           page_base, hdr0, hdr1;

    assign hs = s_axis_tx_tvalid && s_axis_tx_tready;
    assign last_beat = idx == qw - 5'd1;
    assign data_done = state == S_DATA && hs && last_beat;
    assign page_ready = cur_page2 ? huge_page_status_2 : huge_page_status_1;
    assign page_base = cur_page2 ? huge_page_addr_2 : huge_page_addr_1;
    assign closing = state == S_CLOSE_HDR0 || state == S_CLOSE_HDR1;

    rx_tlp_hdr_build u_hdr (
        .length (closing ? 10'd2 : {4'b0, qw, 1'b0}),
        .req_id (cfg_completer_id),
        .addr   (closing ? page_base : page_base + (64'(offset) << 3)),
        .hdr0   (hdr0),
        .hdr1   (hdr1)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= S_IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (send_last_tlp || change_huge_page || trigger_tlp) state_nxt = S_WAIT_PAGE;
            S_WAIT_PAGE:  if (page_ready) state_nxt = req == REQ_CHANGE ? S_CLOSE_HDR0 : S_HDR0;
            S_HDR0:       if (hs) state_nxt = S_HDR1;
            S_HDR1:       if (hs) state_nxt = S_DATA;
            S_DATA:       if (hs && last_beat) state_nxt = req == REQ_LAST ? S_CLOSE_HDR0 : S_ACK;
            S_CLOSE_HDR0: if (hs) state_nxt = S_CLOSE_HDR1;
            S_CLOSE_HDR1: if (hs) state_nxt = S_CLOSE_DATA;
            S_CLOSE_DATA: if (hs) state_nxt = S_SWITCH;
            S_SWITCH:     state_nxt = S_ACK;
            S_ACK:        state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    // rd_addr runs one qword ahead; hold keeps the returned qword while the beat is stalled
    always_comb begin
        s_axis_tx_tvalid = state inside {S_HDR0, S_HDR1, S_DATA, S_CLOSE_HDR0, S_CLOSE_HDR1, S_CLOSE_DATA};
        s_axis_tx_tlast = (state == S_DATA && last_beat) || state == S_CLOSE_DATA;
        s_axis_tx_tkeep = TKEEP_ALL;
        s_axis_tx_tdata = state == S_HDR0 || state == S_CLOSE_HDR0 ? hdr0 :
                          state == S_HDR1 || state == S_CLOSE_HDR1 ? hdr1 :
                          state == S_DATA ? (hold_v ? hold : rd_data) :
                          state == S_CLOSE_DATA ? 64'(offset) : 64'd0;
        rd_addr = rd_ptr + (BF+1)'(state == S_DATA ? idx + 5'd1 : 5'd0);
        trigger_tlp_ack = state == S_ACK && req == REQ_DATA;
        change_huge_page_ack = state == S_ACK && req != REQ_DATA;
        huge_page_free_1 = state == S_SWITCH && !cur_page2;
        huge_page_free_2 = state == S_SWITCH && cur_page2;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req <= REQ_DATA;
            qw <= 5'd0;
            idx <= 5'd0;
            rd_ptr <= '0;
            offset <= (PAGE_QW_BITS+1)'(HDR_QW);
            cur_page2 <= 1'b0;
            hold <= 64'd0;
            hold_v <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                qw <= qwords_to_send;
                req <= send_last_tlp ? REQ_LAST : change_huge_page ? REQ_CHANGE : REQ_DATA;
            end
            if (state == S_HDR1) idx <= 5'd0;
            if (state == S_DATA && hs) idx <= idx + 5'd1;
            if (state == S_DATA && hs) hold_v <= 1'b0;
            else if (state == S_DATA && !hold_v) begin
                hold_v <= 1'b1;
                hold <= rd_data;
            end
            if (data_done) begin
                offset <= offset + (PAGE_QW_BITS+1)'(qw);
                rd_ptr <= rd_ptr + (BF+1)'(qw);
            end
            if (state == S_SWITCH) begin
                cur_page2 <= ~cur_page2;
                offset <= (PAGE_QW_BITS+1)'(HDR_QW);
            end
        end
    end

`ifdef RX_TLP_SENDER_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tlp_count <= 32'd0;
            qword_count <= 32'd0;
        end else begin
            if (hs && s_axis_tx_tlast) tlp_count <= tlp_count + 32'd1;
            if (data_done) qword_count <= qword_count + 32'(qw);
        end
    end
`endif
endmodule

// File: tb/tb_rx_tlp_sender.sv
// tb_rx_tlp_sender: directed scoreboard bench; stimulus pushes expected beats, a monitor pops and compares.
module tb_rx_tlp_sender;
    import rx_tlp_sender_pkg::*;

    typedef struct {logic [63:0] d; logic l;} beat_t;

    logic clk = 0, reset_n = 0;
    logic trigger_tlp = 0, change_huge_page = 0, send_last_tlp = 0;
    logic trigger_tlp_ack, change_huge_page_ack;
    logic [4:0] qwords_to_send = 0;
    logic [BF:0] rd_addr;
    logic [63:0] rd_data = 0;
    logic [63:0] huge_page_addr_1 = 64'h0000_0001_0000_0000;
    logic [63:0] huge_page_addr_2 = 64'h0000_0002_4000_0000;
    logic huge_page_status_1 = 1, huge_page_status_2 = 1;
    logic huge_page_free_1, huge_page_free_2;
    logic [15:0] cfg_completer_id = 16'h0100;
    logic s_axis_tx_tready = 1;
    logic [63:0] s_axis_tx_tdata;
    logic [7:0] s_axis_tx_tkeep;
    logic s_axis_tx_tlast, s_axis_tx_tvalid;
`ifdef RX_TLP_SENDER_STATS_EN
    logic [31:0] tlp_count, qword_count;
`endif

    rx_tlp_sender dut (
        .clk(clk), .reset_n(reset_n),
        .trigger_tlp(trigger_tlp), .trigger_tlp_ack(trigger_tlp_ack),
        .change_huge_page(change_huge_page), .send_last_tlp(send_last_tlp),
        .change_huge_page_ack(change_huge_page_ack), .qwords_to_send(qwords_to_send),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .huge_page_addr_1(huge_page_addr_1), .huge_page_addr_2(huge_page_addr_2),
        .huge_page_status_1(huge_page_status_1), .huge_page_status_2(huge_page_status_2),
        .huge_page_free_1(huge_page_free_1), .huge_page_free_2(huge_page_free_2),
        .cfg_completer_id(cfg_completer_id), .s_axis_tx_tready(s_axis_tx_tready),
        .s_axis_tx_tdata(s_axis_tx_tdata), .s_axis_tx_tkeep(s_axis_tx_tkeep),
        .s_axis_tx_tlast(s_axis_tx_tlast), .s_axis_tx_tvalid(s_axis_tx_tvalid)
`ifdef RX_TLP_SENDER_STATS_EN
        , .tlp_count(tlp_count), .qword_count(qword_count)
`endif
    );

    always #5 clk = ~clk;

    logic [63:0] mem [0:(1<<(BF+1))-1];
    always @(posedge clk) rd_data <= mem[rd_addr];

    function automatic logic [63:0] dat(input int i);
        return {32'hCAFE0000 + 32'(i), 32'h5A5A0000 + 32'(i)};
    endfunction

    int checks = 0, passed = 0;
    int cyc = 0, tl_cyc = -10, beats = 0, tack = 0, cack = 0, f1 = 0, f2 = 0;
    bit tog_en = 0;
    beat_t exp_q[$];
    beat_t e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push(input logic [63:0] d, input logic l);
        exp_q.push_back('{d, l});
    endtask

    task automatic push_hdr(input logic [31:0] h0lo, input logic [63:0] h1);
        push({32'h010000FF, h0lo}, 1'b0);
        push(h1, 1'b0);
    endtask

    task automatic push_data(input int start, input int n);
        for (int i = 0; i < n; i++) push(dat(start + i), i == n - 1);
    endtask

    task automatic push_close(input logic [63:0] h1, input logic [63:0] off);
        push_hdr(32'h60000002, h1);
        push(off, 1'b1);
    endtask

    always @(negedge clk) if (reset_n) begin
        if (s_axis_tx_tvalid && s_axis_tx_tready) begin
            beats++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_beat: got %h expected no beat", s_axis_tx_tdata);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", s_axis_tx_tdata, e.d);
                chk("beat_last", 64'(s_axis_tx_tlast), 64'(e.l));
                chk("beat_tkeep", 64'(s_axis_tx_tkeep), 64'hFF);
            end
            if (s_axis_tx_tlast) tl_cyc = cyc;
        end
        if (trigger_tlp_ack) begin
            tack++;
            chk("ack_latency", 64'(cyc), 64'(tl_cyc + 1));
        end
        if (change_huge_page_ack) begin
            cack++;
            chk("change_ack_latency", 64'(cyc), 64'(tl_cyc + 2));
        end
        if (huge_page_free_1) f1++;
        if (huge_page_free_2) f2++;
    end

    initial forever begin
        @(posedge clk); #1;
        s_axis_tx_tready = tog_en ? ~s_axis_tx_tready : 1'b1;
    end

    task automatic start_req(input int kind, input logic [4:0] n);
        @(posedge clk); #1;
        qwords_to_send = n;
        trigger_tlp = kind == 0;
        send_last_tlp = kind == 1;
        change_huge_page = kind == 2;
    endtask

    task automatic wait_ack(input int kind, input string name);
        int t0 = tack, c0 = cack;
        bit got = 0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk); #1;
            got = kind == 0 ? tack != t0 : cack != c0;
        end
        checks++;
        if (got) passed++;
        else $display("FAIL %s_ack: got none expected ack within 500 cycles", name);
        @(posedge clk); #1;
        trigger_tlp = 0; send_last_tlp = 0; change_huge_page = 0;
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_ctrl"}, 64'({s_axis_tx_tvalid, s_axis_tx_tlast, trigger_tlp_ack,
            change_huge_page_ack, huge_page_free_1, huge_page_free_2}), 64'd0);
        chk({name, "_tdata"}, s_axis_tx_tdata, 64'd0);
        chk({name, "_tkeep"}, 64'(s_axis_tx_tkeep), 64'hFF);
        chk({name, "_rd_addr"}, 64'(rd_addr), 64'd0);
    endtask

    initial begin
        int bad, b0;
        bit got;
        for (int i = 0; i < (1 << (BF + 1)); i++) mem[i] = dat(i);
        repeat (3) @(posedge clk);
        #1 chk_idle_outputs("reset");
        reset_n = 1;
        @(negedge clk) chk_idle_outputs("post_reset");

        // 16-qword TLP with latency probe
        push_hdr(32'h60000020, 64'h00000080_00000001);
        push_data(0, 16);
        start_req(0, 16);
        @(negedge clk) chk("lat_idle", 64'(s_axis_tx_tvalid), 64'd0);
        @(negedge clk) chk("lat_wait", 64'(s_axis_tx_tvalid), 64'd0);
        @(negedge clk) chk("lat_hdr0", 64'(s_axis_tx_tvalid), 64'd1);
        wait_ack(0, "t1");

        // same size, tready toggling
        tog_en = 1;
        push_hdr(32'h60000020, 64'h00000100_00000001);
        push_data(16, 16);
        start_req(0, 16);
        wait_ack(0, "t2");
        tog_en = 0;

        // page not armed
        huge_page_status_1 = 0;
        push_hdr(32'h60000004, 64'h00000180_00000001);
        push_data(32, 2);
        start_req(0, 2);
        bad = 0;
        repeat (10) @(negedge clk) if (s_axis_tx_tvalid) bad++;
        chk("gate_tvalid", 64'(bad), 64'd0);
        @(posedge clk); #1 huge_page_status_1 = 1;
        @(negedge clk) chk("gate_wait", 64'(s_axis_tx_tvalid), 64'd0);
        @(negedge clk) chk("gate_hdr0", 64'(s_axis_tx_tvalid), 64'd1);
        wait_ack(0, "t3");

        // reset while DATA beat 3 is presented
        push_hdr(32'h60000010, 64'h00000190_00000001);
        push_data(34, 8);
        b0 = beats;
        start_req(0, 8);
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk); #1;
            got = beats == b0 + 5;
        end
        checks++;
        if (got) passed++;
        else $display("FAIL reset_wait: got %0d beats expected 5", beats - b0);
        @(posedge clk); #1;
        reset_n = 0;
        trigger_tlp = 0;
        #1 chk_idle_outputs("mid_reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1;

        push_hdr(32'h60000020, 64'h00000080_00000001);
        push_data(0, 16);
        start_req(0, 16);
        wait_ack(0, "t5");

        // send_last: data TLP then close of page 1
        push_hdr(32'h6000000A, 64'h00000100_00000001);
        push_data(16, 5);
        push_close(64'h00000000_00000001, 64'h25);
        start_req(1, 5);
        wait_ack(1, "t6");
        chk("t6_free1", 64'(f1), 64'd1);

        // first TLP in page 2
        push_hdr(32'h60000006, 64'h40000080_00000002);
        push_data(21, 3);
        start_req(0, 3);
        wait_ack(0, "t7");

        push_close(64'h40000000_00000002, 64'h13);
        start_req(2, 0);
        wait_ack(2, "t8");
        chk("t8_free2", 64'(f2), 64'd1);

        push_close(64'h00000000_00000001, 64'h10);
        start_req(2, 0);
        wait_ack(2, "t9");
        chk("t9_free1", 64'(f1), 64'd2);
        chk("trigger_acks", 64'(tack), 64'd5);
        chk("change_acks", 64'(cack), 64'd3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
